// File: rtl/tick_timer.sv
// tick_timer: memory-mapped prescaled 16-bit down-counter with level expiry interrupt
module tick_timer #(
  parameter int RV = 16,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    io_addr,
  input  logic          io_write,
  input  logic          io_read,
  input  logic [RV-1:0] io_wdata,
  output logic [RV-1:0] io_rdata,
  output logic          interrupt
);
  logic          en, periodic, ie, expired, overrun;
  logic [PW-1:0] prescale, pc;
  logic [RV-1:0] reload, count;
  logic          wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
  logic          run, tick, expire, unused_rd;
  logic [1:0]    clr;
  assign wr_ctrl     = io_write & (io_addr == 4'd0);
  assign wr_prescale = io_write & (io_addr == 4'd1);
  assign wr_reload   = io_write & (io_addr == 4'd2);
  assign wr_count    = io_write & (io_addr == 4'd3);
  assign wr_status   = io_write & (io_addr == 4'd4);
  assign unused_rd   = io_read;
  // A CTRL write clearing EN stops the prescaler in that very cycle, suppressing any tick.
  assign run    = en & ~(wr_ctrl & ~io_wdata[0]);
  assign tick   = run & (pc == prescale);
  assign expire = tick & ~wr_count & (count == '0);
  assign clr    = wr_status ? io_wdata[1:0] : 2'b00;
  // Register state: bus writes take priority over the countdown; status set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      reload   <= '0;
      count    <= '0;
      pc       <= '0;
      expired  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      en       <= wr_ctrl ? io_wdata[0] : (expire & ~periodic) ? 1'b0 : en;
      periodic <= wr_ctrl ? io_wdata[1] : periodic;
      ie       <= wr_ctrl ? io_wdata[2] : ie;
      prescale <= wr_prescale ? io_wdata[PW-1:0] : prescale;
      reload   <= wr_reload ? io_wdata : reload;
      count    <= wr_count ? io_wdata : !tick ? count : (count != '0) ? count - RV'(1) : periodic ? reload : count;
      pc       <= (wr_count | (wr_ctrl & io_wdata[0] & ~en) | tick | (wr_prescale & (io_wdata[PW-1:0] < pc))) ? '0 :
                  run ? pc + PW'(1) : pc;
      expired  <= expire | (expired & ~clr[0]);
      overrun  <= (expire & expired & ~clr[0]) | (overrun & ~clr[1]);
    end
  end
  assign io_rdata  = (io_addr == 4'd0) ? RV'({ie, periodic, en}) :
                     (io_addr == 4'd1) ? RV'(prescale) :
                     (io_addr == 4'd2) ? reload :
                     (io_addr == 4'd3) ? count :
                     (io_addr == 4'd4) ? RV'({overrun, expired}) : '0;
  assign interrupt = ie & expired;
endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: scoreboard bench for tick_timer with a rule-level reference model
module tb_tick_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  io_addr = '0;
  logic        io_write = 1'b0;
  logic        io_read = 1'b0;
  logic [15:0] io_wdata = '0;
  logic [15:0] io_rdata;
  logic        interrupt;
  int checks = 0;
  int errors = 0;

  tick_timer #(.RV(16), .PW(16)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_write(io_write), .io_read(io_read),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
    logic        i;
  } exp_t;
  exp_t q[$];

  // Reference model state, kept as plain variables updated by the spec's rules
  bit        m_en, m_per, m_ie, m_exp, m_ovr;
  bit [15:0] m_pre, m_rel, m_cnt, m_pc;

  function automatic logic [15:0] m_rd(input logic [3:0] a);
    if (a == 0) return {13'd0, m_ie, m_per, m_en};
    if (a == 1) return m_pre;
    if (a == 2) return m_rel;
    if (a == 3) return m_cnt;
    if (a == 4) return {14'd0, m_ovr, m_exp};
    return 16'd0;
  endfunction

  task automatic m_clear();
    {m_en, m_per, m_ie, m_exp, m_ovr} = '0;
    m_pre = 0; m_rel = 0; m_cnt = 0; m_pc = 0;
  endtask

  // One bus cycle; expectation pushed from the model or from a fixed constant
  task automatic cyc(input bit w, input bit r, input logic [3:0] a, input logic [15:0] d,
                     input bit use_c, input logic [15:0] cd, input bit ci);
    exp_t e;
    bit en_n, per_n, ie_n, exp_n, ovr_n, dis, tick, fire, expire, cw;
    bit [15:0] pre_n, rel_n, cnt_n, pc_n;
    bit [1:0] clr;
    io_write = w; io_read = r; io_addr = a; io_wdata = d;
    if (r) begin
      e.a = a;
      e.d = use_c ? cd : m_rd(a);
      e.i = use_c ? ci : (m_ie && m_exp);
      q.push_back(e);
    end
    en_n = m_en; per_n = m_per; ie_n = m_ie; exp_n = m_exp; ovr_n = m_ovr;
    pre_n = m_pre; rel_n = m_rel; cnt_n = m_cnt; pc_n = m_pc;
    cw = w && a == 3;
    clr = (w && a == 4) ? d[1:0] : 2'b00;
    dis = w && a == 0 && !d[0];
    fire = m_en && !dis;
    tick = fire && m_pc == m_pre;
    expire = tick && !cw && m_cnt == 0;
    if (fire) pc_n = tick ? 16'd0 : m_pc + 16'd1;
    if (w && a == 1 && d < m_pc) pc_n = 0;
    if (w && a == 0 && d[0] && !m_en) pc_n = 0;
    if (tick && !cw) begin
      if (m_cnt != 0) cnt_n = m_cnt - 16'd1;
      else if (m_per) cnt_n = m_rel;
      else en_n = 0;
    end
    if (clr[0]) exp_n = 0;
    if (clr[1]) ovr_n = 0;
    if (expire) begin
      if (m_exp && !clr[0]) ovr_n = 1;
      exp_n = 1;
    end
    if (w && a == 0) begin en_n = d[0]; per_n = d[1]; ie_n = d[2]; end
    if (w && a == 1) pre_n = d;
    if (w && a == 2) rel_n = d;
    if (cw) begin cnt_n = d; pc_n = 0; end
    @(posedge clk);
    #1;
    m_en = en_n; m_per = per_n; m_ie = ie_n; m_exp = exp_n; m_ovr = ovr_n;
    m_pre = pre_n; m_rel = rel_n; m_cnt = cnt_n; m_pc = pc_n;
    io_write = 0; io_read = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cyc(1, 0, a, d, 0, 0, 0);
  endtask
  task automatic rd(input logic [3:0] a);
    cyc(0, 1, a, 0, 0, 0, 0);
  endtask
  task automatic rdc(input logic [3:0] a, input logic [15:0] v, input bit i);
    cyc(0, 1, a, 0, 1, v, i);
  endtask
  task automatic do_reset();
    reset = 1; io_write = 0; io_read = 0;
    @(posedge clk);
    #1;
    reset = 0;
    m_clear();
  endtask
  task automatic all_zero();
    for (int k = 0; k < 5; k++) rdc(4'(k), 16'd0, 0);
  endtask

  // Monitor: every presented read is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (io_read) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty addr=%0d got rdata=%h", io_addr, io_rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (io_rdata !== e.d || interrupt !== e.i || io_addr !== e.a)
          begin
            errors++;
            $display("FAIL read addr=%0d got rdata=%h int=%b expected rdata=%h int=%b",
                     io_addr, io_rdata, interrupt, e.d, e.i);
          end
      end
    end
  end

  initial begin
    logic [3:0]  a;
    logic [15:0] d;
    int op;
    do_reset();
    all_zero();
    // Periodic: 20-clock period
    wr(1, 3); wr(2, 4); wr(3, 4); wr(0, 7);
    for (int j = 1; j <= 20; j++) rdc(4, 16'd0, 0);
    rdc(4, 16'd1, 1);
    rdc(3, 16'd4, 1);
    wr(4, 1);
    for (int j = 24; j <= 40; j++) rdc(4, 16'd0, 0);
    rdc(4, 16'd1, 1);
    // One-shot
    do_reset();
    wr(1, 0); wr(3, 2); wr(0, 5);
    for (int j = 1; j <= 3; j++) rdc(4, 16'd0, 0);
    rdc(4, 16'd1, 1);
    rdc(0, 16'd4, 1);
    rdc(3, 16'd0, 1);
    wr(4, 1);
    rdc(4, 16'd0, 0);
    // Overrun, W1C collision, COUNT write collision
    do_reset();
    wr(1, 0); wr(2, 2); wr(3, 0); wr(0, 3);
    for (int j = 1; j <= 4; j++) rd(4);
    rdc(4, 16'd3, 0);
    wr(4, 3);
    rdc(4, 16'd0, 0);
    rdc(4, 16'd1, 0);
    rd(4);
    wr(4, 1);
    rdc(4, 16'd1, 0);
    wr(3, 16'h00FF);
    rdc(3, 16'h00FF, 0);
    // Enable gating then re-enable with prescale 7
    wr(0, 0);
    for (int j = 0; j < 50; j++) rdc(3, 16'h00FE, 0);
    wr(1, 7); wr(0, 1);
    for (int j = 1; j <= 8; j++) rdc(3, 16'h00FE, 0);
    rdc(3, 16'h00FD, 0);
    // Mid-operation reset while interrupt is high
    do_reset();
    wr(1, 0); wr(2, 3); wr(3, 0); wr(0, 7);
    rd(4);
    rdc(4, 16'd1, 1);
    do_reset();
    all_zero();
    // Unmapped address
    wr(9, 16'hFFFF);
    rdc(9, 16'd0, 0);
    all_zero();
    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 99);
      a = 4'($urandom_range(0, 15));
      if (a > 5 && $urandom_range(0, 3) != 0) a = 4'($urandom_range(0, 4));
      d = 16'($urandom);
      if (a == 1) d = 16'($urandom_range(0, 3));
      if (a == 2) d = 16'($urandom_range(0, 5));
      if (a == 3) d = 16'($urandom_range(0, 6));
      if (op == 0) do_reset();
      else if (op < 20) wr(a, d);
      else if (op < 70) rd(a);
      else cyc(0, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
